mem_ctrl: RTL and testbench

Memory controller that shares the single byte-wide RAM bus between two requesters: the instruction-fetch stage (port 0, read-only) and the memory-access stage (port 1, load/store). It arbitrates between them, splits each 1/2/4-byte access into sequential byte cycles on the RAM bus, assembles little-endian read data, and returns a one-cycle done pulse. It sits between the pipeline stages and the external RAM.

---
 rtl/mem_ctrl_pkg.sv | 46 ++++
 rtl/mem_ctrl_arb.sv | 52 +++++
 rtl/mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-serial memory controller.
//   state_e      controller FSM encoding (IDLE/READ/WRITE)
//   PORT_*       requester indices used by the arbiter and grant register
//   LEN_*        access length codes in bytes
//   req_t        request payload captured from the granted port
//   len_bytes()  maps a length code onto the number of byte cycles to run
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LEN_BITS = 3;
  localparam int unsigned CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;

  localparam logic [LEN_BITS-1:0] LEN_B = 3'd1;
  localparam logic [LEN_BITS-1:0] LEN_H = 3'd2;
  localparam logic [LEN_BITS-1:0] LEN_W = 3'd4;

  typedef logic [3:0][7:0] word_bytes_t;

  typedef struct packed {
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [LEN_BITS-1:0] len;
  } req_t;

  // 1, 2 and 3 run as-is; every other code becomes a full word.
  function automatic logic [CNT_W-1:0] len_bytes(input logic [LEN_BITS-1:0] len);
    case (len)
      LEN_B:   len_bytes = CNT_W'(LEN_B);
      LEN_H:   len_bytes = CNT_W'(LEN_H);
      3'd3:    len_bytes = CNT_W'(3);
      default: len_bytes = CNT_W'(LEN_W);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: two-way arbiter with a last-grant register.
// Build option: define MEM_CTRL_RR_EN for round-robin on ties; otherwise
// port 1 (memory stage) always wins a tie.
//   clk_i, rst_i  clock, synchronous active-high reset
//   en_i          a grant is taken this cycle if any request is present
//   req_i         request per port, index = PORT_IF / PORT_MEM
//   grant_c_o     combinational winner index
//   valid_c_o     combinational "some port is requesting"
//   last_o        registered index of the most recently granted port
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       grant_c_o,
  output logic       valid_c_o,
  output logic       last_o
);

  logic last_q;

  assign valid_c_o = |req_i;
  assign last_o    = last_q;

  // Winner selection; a lone requester always wins.
  always_comb begin
    grant_c_o = last_q;
    if (req_i[PORT_MEM] && req_i[PORT_IF]) begin
`ifdef MEM_CTRL_RR_EN
      grant_c_o = ~last_q;
`else
      grant_c_o = PORT_MEM;
`endif
    end else if (req_i[PORT_MEM]) begin
      grant_c_o = PORT_MEM;
    end else if (req_i[PORT_IF]) begin
      grant_c_o = PORT_IF;
    end
  end

  // Reset to PORT_IF so the first round-robin tie goes to the memory stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= PORT_IF;
    end else if (en_i && valid_c_o) begin
      last_q <= grant_c_o;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares a byte-wide RAM bus between instruction fetch (port 0,
// read-only) and the memory stage (port 1, load/store). Each 1/2/3/4-byte
// access is split into byte cycles; reads are assembled little-endian.
// Build option: MEM_CTRL_RR_EN selects round-robin arbitration (see mem_ctrl_arb).
//   clk_in, rst_in, rdy_in           clock, sync active-high reset, global enable
//   if_re/addr/len -> if_rdata/done/busy          port 0
//   mem_re/we/addr/wdata/len -> mem_rdata/done/busy  port 1
//   ram_din -> ram_dout/ram_a/ram_wr               RAM bus (1-cycle read latency)
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                if_re,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic [LEN_BITS-1:0] if_len,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  output logic                if_busy,
  input  logic                mem_re,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [LEN_BITS-1:0] mem_len,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_done,
  output logic                mem_busy,
  input  logic [7:0]          ram_din,
  output logic [7:0]          ram_dout,
  output logic [ADDR_W-1:0]   ram_a,
  output logic                ram_wr
);

  state_e            state_q;
  logic              grant_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  n_q;
  word_bytes_t       wdata_q;
  word_bytes_t       buf_q;
  word_bytes_t       buf_d;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic              if_busy_q;
  logic              mem_busy_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;

  req_t              if_req_c;
  req_t              mem_req_c;
  req_t              sel_req_c;
  logic [1:0]        req_vec_c;
  logic              grant_c;
  logic              valid_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // A port whose done is showing is not re-granted in that same cycle.
  assign req_vec_c[PORT_IF]  = if_re & ~if_done_q;
  assign req_vec_c[PORT_MEM] = (mem_re | mem_we) & ~mem_done_q;
  assign cnt_inc_c           = cnt_q + CNT_W'(1);

  // Request payloads; port 0 never writes.
  always_comb begin
    if_req_c        = '0;
    if_req_c.addr   = if_addr;
    if_req_c.len    = if_len;
    mem_req_c       = '0;
    mem_req_c.we    = mem_we;
    mem_req_c.addr  = mem_addr;
    mem_req_c.wdata = mem_wdata;
    mem_req_c.len   = mem_len;
    sel_req_c       = (grant_c == PORT_MEM) ? mem_req_c : if_req_c;
  end

  // ram_din carries the byte addressed in the previous READ cycle.
  always_comb begin
    buf_d = buf_q;
    if (cnt_q != '0) begin
      buf_d[2'(cnt_q - CNT_W'(1))] = ram_din;
    end
  end

  mem_ctrl_arb u_arb (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .en_i      (rdy_in && (state_q == ST_IDLE)),
    .req_i     (req_vec_c),
    .grant_c_o (grant_c),
    .valid_c_o (valid_c),
    .last_o    (grant_q)
  );

  // Controller FSM with registered bus and port outputs; rdy_in low freezes all.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_busy_q   <= 1'b0;
      mem_busy_q  <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else if (rdy_in) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_c) begin
            base_q     <= sel_req_c.addr;
            n_q        <= len_bytes(sel_req_c.len);
            cnt_q      <= '0;
            wdata_q    <= sel_req_c.wdata;
            buf_q      <= '0;
            ram_a_q    <= sel_req_c.addr;
            if_busy_q  <= (grant_c == PORT_IF);
            mem_busy_q <= (grant_c == PORT_MEM);
            if (sel_req_c.we) begin
              state_q    <= ST_WRITE;
              ram_wr_q   <= 1'b1;
              ram_dout_q <= sel_req_c.wdata[7:0];
            end else begin
              state_q    <= ST_READ;
            end
          end
        end
        ST_READ: begin
          cnt_q   <= cnt_inc_c;
          buf_q   <= buf_d;
          ram_a_q <= base_q + ADDR_W'(cnt_inc_c);
          if (cnt_q == n_q) begin
            state_q    <= ST_IDLE;
            if_busy_q  <= 1'b0;
            mem_busy_q <= 1'b0;
            if (grant_q == PORT_MEM) begin
              mem_rdata_q <= buf_d;
              mem_done_q  <= 1'b1;
            end else begin
              if_rdata_q  <= buf_d;
              if_done_q   <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (cnt_inc_c == n_q) begin
            state_q    <= ST_IDLE;
            ram_wr_q   <= 1'b0;
            if_busy_q  <= 1'b0;
            mem_busy_q <= 1'b0;
            mem_done_q <= (grant_q == PORT_MEM);
            if_done_q  <= (grant_q == PORT_IF);
          end else begin
            cnt_q      <= cnt_inc_c;
            ram_a_q    <= base_q + ADDR_W'(cnt_inc_c);
            ram_dout_q <= wdata_q[2'(cnt_inc_c)];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes are masked while frozen; the held values reappear once rdy_in returns.
  assign ram_wr    = ram_wr_q & rdy_in;
  assign if_done   = if_done_q & rdy_in;
  assign mem_done  = mem_done_q & rdy_in;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_busy   = if_busy_q;
  assign mem_busy  = mem_busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a 1 KiB byte RAM model
// (one-cycle read latency, writes on ram_wr at the clock edge).
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        if_re = 1'b0;
  logic [31:0] if_addr = '0;
  logic [2:0]  if_len = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_busy;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [2:0]  mem_len = '0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_busy;
  logic [7:0]  ram_din = '0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  logic [7:0]  mem [0:1023];

  int          total = 0;
  int          bad = 0;

  int          if_done_at;
  int          mem_done_at;
  logic [31:0] if_rd;
  logic [31:0] mem_rd;
  logic [31:0] a_log   [0:31];
  logic [7:0]  dout_log[0:31];
  logic        wr_log  [0:31];
  logic        ifb_log [0:31];
  logic        memb_log[0:31];

`ifdef MEM_CTRL_RR_EN
  localparam bit TIE2_MEM = 1'b0;
`else
  localparam bit TIE2_MEM = 1'b1;
`endif

  mem_ctrl dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .if_re     (if_re),
    .if_addr   (if_addr),
    .if_len    (if_len),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .if_busy   (if_busy),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_len   (mem_len),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .mem_busy  (mem_busy),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr)
  );

  always #5 clk_in = ~clk_in;

  // RAM model
  always @(posedge clk_in) begin
    ram_din <= mem[ram_a[9:0]];
    if (ram_wr) mem[ram_a[9:0]] <= ram_dout;
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    mem[10'h100] <= 8'h11;
    mem[10'h101] <= 8'h22;
    mem[10'h102] <= 8'h33;
    mem[10'h103] <= 8'h44;
    mem[10'h3FF] <= 8'hA5;
    mem[10'h000] <= 8'h5A;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  // Run ncyc cycles after the request cycle; log bus activity, drop a port's
  // request on its done. stall_at>0 holds rdy_in low for two cycles there.
  task automatic run(input int ncyc, input int stall_at, input bit withdraw_if);
    if_done_at  = 0;
    mem_done_at = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk_in);
      #1;
      rdy_in = !(stall_at != 0 && (i == stall_at || i == stall_at + 1));
      #1;
      a_log[i]    = ram_a;
      dout_log[i] = ram_dout;
      wr_log[i]   = ram_wr;
      ifb_log[i]  = if_busy;
      memb_log[i] = mem_busy;
      if (if_done && if_done_at == 0) begin
        if_done_at = i;
        if_rd      = if_rdata;
        if_re      = 1'b0;
      end
      if (mem_done && mem_done_at == 0) begin
        mem_done_at = i;
        mem_rd      = mem_rdata;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        if (withdraw_if) if_re = 1'b0;
      end
    end
    rdy_in = 1'b1;
  endtask

  initial begin
    int          done_cnt;
    logic [31:0] wr_bits;

    // Reset state
    repeat (3) step();
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_wr", 32'(ram_wr), 32'h0);
    check("rst_if_done", 32'(if_done), 32'h0);
    check("rst_mem_done", 32'(mem_done), 32'h0);
    check("rst_if_busy", 32'(if_busy), 32'h0);
    check("rst_mem_busy", 32'(mem_busy), 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    rst_in = 1'b0;
    step();

    // Tie straight after reset: port 1 wins; port 0 withdraws at mem_done
    if_re = 1'b1; if_addr = 32'h100; if_len = 3'd1;
    mem_re = 1'b1; mem_addr = 32'h102; mem_len = 3'd1;
    run(8, 0, 1'b1);
    check("tie1_mem_done_at", 32'(mem_done_at), 32'd3);
    check("tie1_mem_busy1", 32'(memb_log[1]), 32'h1);
    check("tie1_if_busy1", 32'(ifb_log[1]), 32'h0);
    check("tie1_mem_busy_done", 32'(memb_log[3]), 32'h0);
    check("tie1_mem_rdata", mem_rd, 32'h0000_0033);
    check("tie1_if_not_granted", 32'(ifb_log[4]), 32'h0);
    check("tie1_if_done_at", 32'(if_done_at), 32'd0);

    // Second tie: fixed priority repeats port 1, round-robin hands it to port 0
    if_re = 1'b1; if_addr = 32'h100; if_len = 3'd1;
    mem_re = 1'b1; mem_addr = 32'h102; mem_len = 3'd1;
    run(10, 0, 1'b0);
    check("tie2_win_done", 32'(TIE2_MEM ? mem_done_at : if_done_at), 32'd3);
    check("tie2_lose_done", 32'(TIE2_MEM ? if_done_at : mem_done_at), 32'd6);
    check("tie2_win_busy1", 32'(TIE2_MEM ? memb_log[1] : ifb_log[1]), 32'h1);
    check("tie2_lose_busy1", 32'(TIE2_MEM ? ifb_log[1] : memb_log[1]), 32'h0);
    check("tie2_lose_busy4", 32'(TIE2_MEM ? ifb_log[4] : memb_log[4]), 32'h1);
    check("tie2_if_rdata", if_rd, 32'h0000_0011);
    check("tie2_mem_rdata", mem_rd, 32'h0000_0033);

    // Port 0 word read
    if_re = 1'b1; if_addr = 32'h100; if_len = 3'd4;
    run(9, 0, 1'b0);
    check("rd4_done_at", 32'(if_done_at), 32'd6);
    check("rd4_rdata", if_rd, 32'h4433_2211);
    for (int k = 0; k < 4; k++) check("rd4_ram_a", a_log[k+1], 32'h100 + 32'(k));

    // Port 1 halfword write
    mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF; mem_len = 3'd2;
    run(6, 0, 1'b0);
    check("wr2_done_at", 32'(mem_done_at), 32'd3);
    check("wr2_wr1", 32'(wr_log[1]), 32'h1);
    check("wr2_wr2", 32'(wr_log[2]), 32'h1);
    check("wr2_wr3", 32'(wr_log[3]), 32'h0);
    check("wr2_dout1", 32'(dout_log[1]), 32'hEF);
    check("wr2_dout2", 32'(dout_log[2]), 32'hBE);
    check("wr2_mem200", 32'(mem[10'h200]), 32'hEF);
    check("wr2_mem201", 32'(mem[10'h201]), 32'hBE);
    check("wr2_mem202", 32'(mem[10'h202]), 32'h00);

    // Length 3 on port 0, length 0 (whole word) on port 1
    if_re = 1'b1; if_addr = 32'h100; if_len = 3'd3;
    run(8, 0, 1'b0);
    check("rd3_done_at", 32'(if_done_at), 32'd5);
    check("rd3_rdata", if_rd, 32'h0033_2211);
    mem_re = 1'b1; mem_addr = 32'h100; mem_len = 3'd0;
    run(9, 0, 1'b0);
    check("rd0_done_at", 32'(mem_done_at), 32'd6);
    check("rd0_rdata", mem_rd, 32'h4433_2211);

    // Word write with a two-cycle stall after the second byte
    mem_we = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h0403_0201; mem_len = 3'd4;
    run(10, 3, 1'b0);
    wr_bits = '0;
    for (int k = 1; k <= 7; k++) wr_bits[k] = wr_log[k];
    check("stall_wr_pattern", wr_bits, 32'h66);
    check("stall_done_at", 32'(mem_done_at), 32'd7);
    check("stall_ram_a5", a_log[5], 32'h302);
    for (int k = 0; k < 4; k++) check("stall_mem", 32'(mem[10'h300 + 10'(k)]), 32'(k + 1));

    // Reset during READ with cnt=1
    if_re = 1'b1; if_addr = 32'h100; if_len = 3'd4;
    step();
    step();
    rst_in = 1'b1;
    if_re  = 1'b0;
    step();
    check("mrst_if_busy", 32'(if_busy), 32'h0);
    check("mrst_ram_a", ram_a, 32'h0);
    check("mrst_ram_wr", 32'(ram_wr), 32'h0);
    check("mrst_if_done", 32'(if_done), 32'h0);
    check("mrst_if_rdata", if_rdata, 32'h0);
    check("mrst_mem_rdata", mem_rdata, 32'h0);
    rst_in = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (if_done) done_cnt++;
    end
    check("mrst_no_done", 32'(done_cnt), 32'd0);

    // Top-of-memory reads: zero upper bytes, address wrap
    mem_re = 1'b1; mem_addr = 32'hFFFF_FFFF; mem_len = 3'd1;
    run(6, 0, 1'b0);
    check("wrap1_done_at", 32'(mem_done_at), 32'd3);
    check("wrap1_rdata", mem_rd, 32'h0000_00A5);
    mem_re = 1'b1; mem_addr = 32'hFFFF_FFFF; mem_len = 3'd2;
    run(7, 0, 1'b0);
    check("wrap2_ram_a1", a_log[1], 32'hFFFF_FFFF);
    check("wrap2_ram_a2", a_log[2], 32'h0000_0000);
    check("wrap2_done_at", 32'(mem_done_at), 32'd4);
    check("wrap2_rdata", mem_rd, 32'h0000_5AA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
